// File: rtl/pc_redirect_unit.sv
// PC stage: holds the PC, computes PC+4 and the branch/jump targets, picks the next PC, and
// runs a short flush sequence after every taken redirect so wrong-path fetches are marked.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic        branch_ne_i,
   input  logic        zero_i,
   input  logic [31:0] shifted_offset_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] branch_target_o,
   output logic        fetch_valid_o,
   output logic        flush_o,
   output logic [7:0]  redirect_cnt_o
);

   typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

   localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

   state_e      state_q;
   logic [31:0] pc_q;
   logic [3:0]  cnt_q;
   logic [7:0]  redir_q;
   logic        fetch_valid_q;
   logic        flush_q;

   logic [31:0] jump_target;
   logic        taken;

   always_comb begin
      pc_plus4_o      = pc_q + 32'd4;
      branch_target_o = pc_plus4_o + shifted_offset_i;
      jump_target     = {pc_plus4_o[31:28], jump_index_i, 2'b00};
      taken           = branch_i & (zero_i ^ branch_ne_i);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         cnt_q         <= 4'd0;
         redir_q       <= 8'd0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
      end else if (!stall_i) begin
         unique case (state_q)
            StBoot: begin
               state_q       <= StRun;
               fetch_valid_q <= 1'b1;
               flush_q       <= 1'b0;
            end
            StRun: begin
               if (jump_i || taken) begin
                  // Jump has priority over a simultaneous taken branch.
                  pc_q          <= jump_i ? jump_target : branch_target_o;
                  cnt_q         <= FlushInit;
                  state_q       <= StFlush;
                  fetch_valid_q <= 1'b0;
                  flush_q       <= 1'b1;
                  if (redir_q != 8'hFF) redir_q <= redir_q + 8'd1;
               end else begin
                  pc_q <= pc_plus4_o;
               end
            end
            StFlush: begin
               pc_q  <= pc_plus4_o;
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_q       <= StRun;
                  fetch_valid_q <= 1'b1;
                  flush_q       <= 1'b0;
               end
            end
            default: begin
               state_q       <= StBoot;
               fetch_valid_q <= 1'b0;
               flush_q       <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o           = pc_q;
   assign fetch_valid_o  = fetch_valid_q;
   assign flush_o        = flush_q;
   assign redirect_cnt_o = redir_q;

endmodule
